// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : alu_pkg
//  Brief   : Shared constants and types for the ALU operand stage: ALU
//            control codes, main-decoder op classes, R-type funct codes and
//            the registered EX control bundle.
//  Rev     : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

  // 4-bit ALU control codes presented to the ALU
  localparam logic [3:0] ALU_AND     = 4'd0;
  localparam logic [3:0] ALU_OR      = 4'd1;
  localparam logic [3:0] ALU_ADD     = 4'd2;
  localparam logic [3:0] ALU_SUB     = 4'd6;
  localparam logic [3:0] ALU_SLT     = 4'd7;
  localparam logic [3:0] ALU_NOR     = 4'd12;
  localparam logic [3:0] ALU_ILLEGAL = 4'd15;

  // Main-decoder ALU op class
  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_RTYPE = 2'b10,
    OP_OR    = 2'b11
  } alu_op_e;

  // R-type funct field values
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_NOR = 6'h27;

  // Control bundle held in the ID/EX register
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       illegal;
    logic [3:0] alu_ctrl;
  } ex_ctrl_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_ctrl_dec.sv
`default_nettype none
// ============================================================================
//  Module  : alu_ctrl_dec
//  Brief   : Combinational ALU control decoder. Maps the main-decoder op
//            class and the R-type funct field onto the 4-bit ALU control
//            code; unknown R-type functs yield ALU_ILLEGAL and flag illegal.
//  Rev     : 1.0  initial release
// ============================================================================
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       illegal_o
);

  // Op class selects the operation directly except for R-type, which defers to funct
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    illegal_o  = 1'b0;
    case (alu_op_i)
      OP_ADD: alu_ctrl_o = ALU_ADD;
      OP_SUB: alu_ctrl_o = ALU_SUB;
      OP_OR:  alu_ctrl_o = ALU_OR;
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          FN_NOR:  alu_ctrl_o = ALU_NOR;
          default: begin
            alu_ctrl_o = ALU_ILLEGAL;
            illegal_o  = 1'b1;
          end
        endcase
      end
      default: begin
        alu_ctrl_o = ALU_ADD;
        illegal_o  = 1'b0;
      end
    endcase
  end

endmodule : alu_ctrl_dec
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module  : alu_operand_stage
//  Brief   : ID/EX pipeline register with ALU control decode, EX/MEM and
//            MEM/WB operand forwarding, and load-use hazard detection.
//            Register update priority: flush > hold > load-use bubble > load.
//  Rev     : 1.0  initial release
// ============================================================================
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [1:0]            id_alu_op,
  input  logic [5:0]            id_funct,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  ex_hold,
  input  logic                  ex_flush,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]     mem_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_result,
  output logic [3:0]            alu_ctrl,
  output logic [DATA_W-1:0]     alu_in1,
  output logic [DATA_W-1:0]     alu_in2,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic                  ex_illegal,
  output logic                  load_use_stall
);

  // Registered state
  ex_ctrl_t               ctrl_q, ctrl_d;
  logic [REG_ADDR_W-1:0]  rs_q, rs_d;
  logic [REG_ADDR_W-1:0]  rt_q, rt_d;
  logic [REG_ADDR_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0]      rs_data_q, rs_data_d;
  logic [DATA_W-1:0]      rt_data_q, rt_data_d;
  logic [DATA_W-1:0]      imm_q, imm_d;

  // Combinational helpers
  logic [3:0]             dec_ctrl;
  logic                   dec_illegal;
  logic                   stall;
  logic [DATA_W-1:0]      fwd_rs;
  logic [DATA_W-1:0]      fwd_rt;

  alu_ctrl_dec u_alu_ctrl_dec (
    .alu_op_i   (id_alu_op),
    .funct_i    (id_funct),
    .alu_ctrl_o (dec_ctrl),
    .illegal_o  (dec_illegal)
  );

  // Load-use hazard: a valid load in EX whose destination feeds the ID instruction.
  // rt only matters when the ID instruction actually reads it as ALU input 2.
  always_comb begin
    stall = 1'b0;
    if (!ex_hold && ctrl_q.valid && ctrl_q.mem_read && (rd_q != '0) && id_valid) begin
      stall = (rd_q == id_rs) || ((rd_q == id_rt) && !id_alu_src);
    end
  end

  // Next-state selection: flush beats hold, hold beats the load-use bubble
  always_comb begin
    ctrl_d    = ctrl_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    if (ex_flush || (!ex_hold && stall)) begin
      // Bubble: nothing valid, nothing writes, ALU idles on add.
      // Source addresses cleared so the bubble never matches a forward.
      ctrl_d          = '0;
      ctrl_d.alu_ctrl = ALU_ADD;
      rs_d            = '0;
      rt_d            = '0;
      rd_d            = '0;
    end else if (!ex_hold) begin
      ctrl_d.valid     = id_valid;
      ctrl_d.reg_write = id_valid & id_reg_write;
      ctrl_d.mem_read  = id_valid & id_mem_read;
      ctrl_d.mem_write = id_valid & id_mem_write;
      ctrl_d.alu_src   = id_alu_src;
      ctrl_d.illegal   = id_valid & dec_illegal;
      ctrl_d.alu_ctrl  = dec_ctrl;
      rs_d             = id_rs;
      rt_d             = id_rt;
      rd_d             = id_rd;
      rs_data_d        = id_rs_data;
      rt_data_d        = id_rt_data;
      imm_d            = id_imm;
    end
  end

  // ID/EX pipeline register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
    end
  end

  // rs forwarding: the younger EX/MEM result wins over MEM/WB; r0 never forwards
  always_comb begin
    fwd_rs = rs_data_q;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs_q)) begin
      fwd_rs = mem_result;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs_q)) begin
      fwd_rs = wb_result;
    end
  end

  // rt forwarding, same priority as rs
  always_comb begin
    fwd_rt = rt_data_q;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rt_q)) begin
      fwd_rt = mem_result;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rt_q)) begin
      fwd_rt = wb_result;
    end
  end

  assign alu_ctrl       = ctrl_q.alu_ctrl;
  assign alu_in1        = fwd_rs;
  assign alu_in2        = ctrl_q.alu_src ? imm_q : fwd_rt;
  assign ex_store_data  = fwd_rt;
  assign ex_valid       = ctrl_q.valid;
  assign ex_reg_write   = ctrl_q.reg_write;
  assign ex_mem_read    = ctrl_q.mem_read;
  assign ex_mem_write   = ctrl_q.mem_write;
  assign ex_rd          = rd_q;
  assign ex_illegal     = ctrl_q.illegal;
  assign load_use_stall = stall;

endmodule : alu_operand_stage
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_alu_operand_stage
//  Brief   : Directed-vector bench for alu_operand_stage. Stimulus pushes
//            expected values tagged with the cycle they must appear in; a
//            monitor on the falling edge pops and compares them.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_alu_operand_stage;

  localparam int S_CTRL  = 0;
  localparam int S_IN1   = 1;
  localparam int S_IN2   = 2;
  localparam int S_VALID = 3;
  localparam int S_REGW  = 4;
  localparam int S_ILL   = 5;
  localparam int S_STALL = 6;
  localparam int S_STORE = 7;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
  logic        ex_hold, ex_flush;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_in1, alu_in2, ex_store_data;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;
  logic        ex_illegal, load_use_stall;

  alu_operand_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_funct(id_funct), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .ex_hold(ex_hold), .ex_flush(ex_flush),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .alu_ctrl(alu_ctrl), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
    .ex_illegal(ex_illegal), .load_use_stall(load_use_stall)
  );

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;
  logic [31:0] act;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt = cyc_cnt + 1;

  function automatic logic [31:0] get_act(input int sel);
    case (sel)
      S_CTRL:  return {28'd0, alu_ctrl};
      S_IN1:   return alu_in1;
      S_IN2:   return alu_in2;
      S_VALID: return {31'd0, ex_valid};
      S_REGW:  return {31'd0, ex_reg_write};
      S_ILL:   return {31'd0, ex_illegal};
      S_STALL: return {31'd0, load_use_stall};
      S_STORE: return ex_store_data;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      cur = sb.pop_front();
      checks = checks + 1;
      act = get_act(cur.sel);
      if (cur.cyc < cyc_cnt) begin
        errors = errors + 1;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", cur.name, cur.cyc, cyc_cnt);
      end else if (act !== cur.exp) begin
        errors = errors + 1;
        $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", cur.name, act, cur.exp, cyc_cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dly, input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc_cnt + dly;
    e.sel  = sel;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic issue(input logic v, input int rs, input int rt, input int rd,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                       input logic [1:0] op, input logic [5:0] fn, input logic src,
                       input logic rw, input logic mr, input logic mw);
    id_valid     = v;
    id_rs        = rs[4:0];
    id_rt        = rt[4:0];
    id_rd        = rd[4:0];
    id_rs_data   = rsd;
    id_rt_data   = rtd;
    id_imm       = imm;
    id_alu_op    = op;
    id_funct     = fn;
    id_alu_src   = src;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_mem_write = mw;
  endtask

  logic [5:0] fn_tab [5];
  logic [3:0] ct_tab [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fn_tab[0] = 6'h24; ct_tab[0] = 4'd0;
    fn_tab[1] = 6'h25; ct_tab[1] = 4'd1;
    fn_tab[2] = 6'h2A; ct_tab[2] = 4'd7;
    fn_tab[3] = 6'h27; ct_tab[3] = 4'd12;
    fn_tab[4] = 6'h22; ct_tab[4] = 4'd6;

    rst_n = 1'b0;
    ex_hold = 1'b0; ex_flush = 1'b0;
    mem_reg_write = 1'b0; mem_rd = '0; mem_result = '0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;
    issue(0, 0, 0, 0, 0, 0, 0, 2'b00, 6'h00, 0, 0, 0, 0);

    // Reset state
    tick(); tick();
    expect_at(0, S_VALID, 0, "rst_valid");
    expect_at(0, S_CTRL,  0, "rst_ctrl");
    expect_at(0, S_STALL, 0, "rst_stall");
    expect_at(0, S_IN1,   0, "rst_in1");
    tick();
    rst_n = 1'b1;
    tick();

    // R-type add
    issue(1, 1, 2, 3, 32'd5, 32'd7, 0, 2'b10, 6'h20, 0, 1, 0, 0);
    expect_at(1, S_CTRL,  2, "radd_ctrl");
    expect_at(1, S_IN1,   5, "radd_in1");
    expect_at(1, S_IN2,   7, "radd_in2");
    expect_at(1, S_VALID, 1, "radd_valid");
    tick();

    // Double forward: EX/MEM beats MEM/WB
    issue(1, 3, 0, 5, 32'h99, 0, 0, 2'b00, 6'h00, 0, 1, 0, 0);
    mem_reg_write = 1'b1; mem_rd = 5'd3; mem_result = 32'h11;
    wb_reg_write  = 1'b1; wb_rd  = 5'd3; wb_result  = 32'h22;
    expect_at(1, S_IN1, 32'h11, "fwd_mem_wins");
    tick();
    ex_hold = 1'b1;
    tick();
    mem_reg_write = 1'b0;
    expect_at(0, S_IN1, 32'h22, "fwd_wb");
    ex_hold = 1'b0;
    issue(1, 0, 0, 5, 32'h33, 0, 0, 2'b00, 6'h00, 0, 1, 0, 0);
    tick();
    mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'h11;
    wb_reg_write  = 1'b1; wb_rd  = 5'd0; wb_result  = 32'h22;
    expect_at(0, S_IN1, 32'h33, "fwd_r0_none");
    tick();

    // Load-use: lw r4 in EX, add reads r4
    mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    issue(1, 0, 0, 4, 32'h100, 0, 32'd8, 2'b00, 6'h00, 1, 1, 1, 0);
    tick();
    issue(1, 4, 5, 6, 32'hDEAD, 32'd3, 0, 2'b10, 6'h20, 0, 1, 0, 0);
    expect_at(0, S_STALL, 1, "lu_stall");
    expect_at(0, S_IN1, 32'h100, "lu_lw_in1");
    expect_at(0, S_IN2, 32'd8, "lu_lw_in2");
    expect_at(1, S_VALID, 0, "lu_bubble");
    tick();
    expect_at(0, S_STALL, 0, "lu_stall_clear");
    tick();
    wb_reg_write = 1'b1; wb_rd = 5'd4; wb_result = 32'h40;
    id_valid = 1'b0;
    expect_at(0, S_IN1, 32'h40, "lu_fwd_wb");
    expect_at(0, S_IN2, 32'd3, "lu_in2");
    expect_at(0, S_VALID, 1, "lu_add_valid");
    tick();

    // Hold then flush-under-hold
    wb_reg_write = 1'b0;
    issue(1, 7, 8, 9, 32'd20, 32'd9, 0, 2'b01, 6'h00, 0, 1, 0, 0);
    expect_at(1, S_CTRL, 6, "sub_ctrl");
    tick();
    ex_hold = 1'b1;
    issue(1, 1, 2, 10, 32'hAAAA, 32'hBBBB, 0, 2'b11, 6'h00, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      expect_at(1, S_IN1, 32'd20, "hold_in1");
      expect_at(1, S_CTRL, 6, "hold_ctrl");
      expect_at(1, S_VALID, 1, "hold_valid");
      tick();
    end
    ex_flush = 1'b1;
    expect_at(1, S_VALID, 0, "flush_valid");
    expect_at(1, S_REGW, 0, "flush_regw");
    expect_at(1, S_CTRL, 2, "flush_ctrl");
    tick();
    ex_flush = 1'b0; ex_hold = 1'b0;

    // Immediate operand and store-data forwarding
    issue(1, 0, 9, 11, 32'd1, 32'h55, 32'hFFFF_FFFC, 2'b00, 6'h00, 1, 1, 0, 0);
    expect_at(1, S_CTRL, 2, "imm_ctrl");
    expect_at(1, S_IN2, 32'hFFFF_FFFC, "imm_in2");
    expect_at(1, S_ILL, 0, "imm_ill");
    tick();
    mem_reg_write = 1'b1; mem_rd = 5'd9; mem_result = 32'h77;
    expect_at(0, S_STORE, 32'h77, "store_fwd");
    issue(1, 1, 2, 3, 0, 0, 0, 2'b10, 6'h3F, 0, 1, 0, 0);
    expect_at(1, S_CTRL, 15, "ill_ctrl");
    expect_at(1, S_ILL, 1, "ill_flag");
    tick();
    mem_reg_write = 1'b0;

    // Remaining funct decodes and op class 11
    for (int i = 0; i < 5; i++) begin
      issue(1, 1, 2, 3, 0, 0, 0, 2'b10, fn_tab[i], 0, 1, 0, 0);
      expect_at(1, S_CTRL, {28'd0, ct_tab[i]}, "funct_dec");
      tick();
    end
    issue(1, 1, 2, 3, 0, 0, 0, 2'b11, 6'h00, 0, 1, 0, 0);
    expect_at(1, S_CTRL, 1, "op_or");
    tick();
    issue(0, 1, 2, 3, 0, 0, 0, 2'b10, 6'h3F, 0, 1, 0, 0);
    expect_at(1, S_ILL, 0, "ill_invalid");
    expect_at(1, S_VALID, 0, "invalid_valid");
    expect_at(1, S_REGW, 0, "invalid_regw");
    tick();

    // Reset mid-stall
    issue(1, 0, 0, 4, 32'h100, 0, 32'd8, 2'b00, 6'h00, 1, 1, 1, 0);
    tick();
    issue(1, 4, 5, 6, 32'd1, 32'd2, 0, 2'b10, 6'h20, 0, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    expect_at(0, S_VALID, 0, "mrst_valid");
    expect_at(0, S_CTRL, 0, "mrst_ctrl");
    expect_at(0, S_STALL, 0, "mrst_stall");
    expect_at(0, S_IN1, 0, "mrst_in1");
    tick();
    rst_n = 1'b1;
    id_valid = 1'b0;
    tick(); tick();

    if (sb.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_operand_stage
`default_nettype wire

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage sitting directly upstream of the ALU.
- Captures decoded instruction fields each cycle and decodes ALU op/funct into the 4-bit ALU control code.
- Resolves EX/MEM and MEM/WB data forwarding and drives the ALU's control and operand inputs.
- Detects load-use hazards and inserts bubbles.

Parameters:
DATA_W, 32, operand/result width
REG_ADDR_W, 5, register-file address width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode slot holds a real instruction
id_rs_data  in  DATA_W  register-file read port 1
id_rt_data  in  DATA_W  register-file read port 2
id_imm  in  DATA_W  sign/zero-extended immediate
id_rs, id_rt, id_rd  in  REG_ADDR_W  source/destination register numbers
id_alu_op  in  2  main-decoder ALU op class
id_funct  in  6  R-type funct field
id_alu_src  in  1  1 selects immediate as ALU input 2
id_reg_write, id_mem_read, id_mem_write  in  1  control bits
ex_hold  in  1  freeze stage (downstream memory wait)
ex_flush  in  1  squash the instruction entering EX (branch taken)
mem_reg_write  in  1  EX/MEM writes a register
mem_rd  in  REG_ADDR_W  EX/MEM destination
mem_result  in  DATA_W  EX/MEM ALU result
wb_reg_write  in  1  MEM/WB writes a register
wb_rd  in  REG_ADDR_W  MEM/WB destination
wb_result  in  DATA_W  MEM/WB writeback value
alu_ctrl  out  4  to ALU control input
alu_in1  out  DATA_W  to ALU input 1
alu_in2  out  DATA_W  to ALU input 2
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control
ex_rd  out  REG_ADDR_W  registered destination
ex_store_data  out  DATA_W  forwarded rt value for stores
ex_illegal  out  1  unrecognised op/funct in EX
load_use_stall  out  1  tells IF/ID to hold

Behaviour:
- Reset (async, rst_n=0): all registered state 0. Outputs: ex_valid=0, all ex_* controls=0, ex_rd=0, alu_ctrl=0.
- alu_in1, alu_in2 and ex_store_data are combinational from the registered operands (0 during reset); load_use_stall=0.
- Update priority per rising edge: ex_flush > ex_hold > load_use_stall > normal load.
  - flush: load a bubble; valid and all control bits 0, alu_ctrl=2, data don't-care. Applies even when ex_hold=1.
  - hold: all registers keep their value.
  - load_use_stall: load a bubble. IF/ID is held externally, so the same instruction re-presents next cycle.
  - normal: capture all id_* fields. Control bits are gated by id_valid.
- load_use_stall = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & (ex_rd==id_rs | (ex_rd==id_rt & !id_alu_src)). Combinational. Forced 0 while ex_hold=1.
- ALU control decode at capture (sub-module), applied to id_alu_op:
  - 00 → 2 (add)
  - 01 → 6 (sub)
  - 11 → 1 (or)
  - 10 → decode id_funct: 0x20→2, 0x22→6, 0x24→0, 0x25→1, 0x2A→7, 0x27→12, any other → 15 with ex_illegal=1.
  - ex_illegal is registered and only asserted when the captured instruction is valid.
- Forwarding, for operand X in {rs, rt}:
  - if mem_reg_write & mem_rd!=0 & mem_rd==ex_X → mem_result;
  - else if wb_reg_write & wb_rd!=0 & wb_rd==ex_X → wb_result;
  - else the captured register data.
  - EX/MEM always beats MEM/WB. Register 0 is never forwarded.
- alu_in1 = forwarded rs.
- alu_in2 = ex_alu_src ? ex_imm : forwarded rt.
- ex_store_data = forwarded rt, regardless of alu_src.
- Latency: one cycle from id_* to alu_* outputs. Forwarding muxes add no cycle.
- Reset mid-hold or mid-stall: all state clears immediately; no pending stall survives.

Decomposition:
- Package alu_pkg holds:
  - ALU control constants: AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12, ILLEGAL=15;
  - alu_op encodings;
  - funct constants;
  - DATA_W and REG_ADDR_W defaults.
- One sub-module, alu_ctrl_dec: purely combinational (alu_op, funct) → (alu_ctrl, illegal).

Test Plan:
- Reset: rst_n=0 mid-stream → ex_valid=0 and alu_ctrl=0 immediately, without waiting for a clock edge; load_use_stall=0.
- R-type add: id_alu_op=10, funct=0x20, rs_data=5, rt_data=7 → next cycle alu_ctrl=2, alu_in1=5, alu_in2=7, ex_valid=1.
- Double forward: ex_rs=3, mem_rd=3 (mem_result=0x11), wb_rd=3 (wb_result=0x22), both write → alu_in1=0x11. Drop mem_reg_write → alu_in1=0x22. Set mem_rd=0 with ex_rs=0 → no forward.
- Load-use: EX holds lw to rd=4; ID add uses rs=4 → load_use_stall=1, next cycle ex_valid=0. The re-presented add then forwards from MEM/WB.
- Hold/flush priority: ex_hold=1 for 3 cycles → outputs frozen. Assert ex_hold=1 and ex_flush=1 together → bubble loaded (ex_valid=0, ex_reg_write=0).
- Immediate/illegal: alu_src=1, imm=0xFFFFFFFC, op=00 → alu_ctrl=2, alu_in2=0xFFFFFFFC. op=10 with funct=0x3F → alu_ctrl=15, ex_illegal=1.
